// File: rtl/mode_btn_cond_if.sv
// Front-panel button bundle: raw bouncing buttons in, conditioned mode levels out.
// Master is the board/pin side; slave is the conditioning block.
interface mode_btn_cond_if;
  logic up_btn;
  logic down_btn;
  logic sel_btn;
  logic up;
  logic down;
  logic sel;

  modport master (output up_btn, down_btn, sel_btn, input up, down, sel);
  modport slave  (input up_btn, down_btn, sel_btn, output up, down, sel);
endinterface

// File: rtl/mode_btn_cond.sv
// Syncs and debounces UP/DOWN/SEL, then shapes UP/DOWN into interlocked mode steps with
// hold-to-repeat low gaps. Outputs are registered; raw edge to output is 2 + DEBOUNCE_CYC + 1 cycles.
module mode_btn_cond #(
  parameter bit BTN_ACT_LOW  = 1'b1,
  parameter int DEBOUNCE_CYC = 20000,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int REPEAT_DLY   = 500000,
  parameter int REPEAT_PER   = 250000,
  parameter int GAP_CYC      = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  mode_btn_cond_if.slave btn
);
  localparam int MAX_A = (DEBOUNCE_CYC > REPEAT_DLY) ? DEBOUNCE_CYC : REPEAT_DLY;
  localparam int MAX_B = (REPEAT_PER > GAP_CYC) ? REPEAT_PER : GAP_CYC;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2, RPT = 2'd3} st_e;

  logic [2:0] raw;
  logic [2:0] db;
  logic [1:0] idle_v;
  logic [1:0] out_v;
  logic       sel_q, sel_d;

  // Channel order: 0 = UP, 1 = DOWN, 2 = SEL.
  assign raw = {btn.sel_btn, btn.down_btn, btn.up_btn};

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic          sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d = raw[g] ^ BTN_ACT_LOW;
      sync2_d = sync1_q;
      db_d    = db_q;
      cnt_d   = '0;
      if (sync2_q != db_q) begin
        if (cnt_q == DB_LAST) db_d = sync2_q;
        else                  cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        db_q    <= db_d;
        cnt_q   <= cnt_d;
      end
    end

    assign db[g] = db_q;
  end

  for (genvar g = 0; g < 2; g++) begin : g_fsm
    localparam int O = 1 - g;
    st_e           st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blk_q, blk_d, out_q, out_d;

    always_comb begin
      st_d  = st_q;
      cnt_d = '0;
      // A press seen while the other channel is busy stays dead until it is released.
      blk_d = db[g] & (blk_q | ((st_q == IDLE) & ~idle_v[O]));
      case (st_q)
        IDLE: if (db[g] && !blk_q && idle_v[O] && !db[O]) st_d = HOLD;
        HOLD: begin
          if (!db[g]) st_d = IDLE;
          else if (REPEAT_EN) begin
            if (cnt_q == DLY_LAST) st_d = GAP;
            else                   cnt_d = cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) st_d = db[g] ? RPT : IDLE;
          else                   cnt_d = cnt_q + CW'(1);
        end
        RPT: begin
          if (!db[g])                 st_d = IDLE;
          else if (cnt_q == PER_LAST) st_d = GAP;
          else                        cnt_d = cnt_q + CW'(1);
        end
        default: st_d = IDLE;
      endcase
      out_d = (st_d == HOLD) || (st_d == RPT);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        blk_q <= 1'b0;
        out_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        blk_q <= blk_d;
        out_q <= out_d;
      end
    end

    assign idle_v[g] = (st_q == IDLE);
    assign out_v[g]  = out_q;
  end

  always_comb sel_d = db[2];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sel_q <= 1'b0;
    else        sel_q <= sel_d;
  end

  assign btn.up   = out_v[0];
  assign btn.down = out_v[1];
  assign btn.sel  = sel_q;
endmodule
